// File: rtl/clmul_pkg.sv
// -----------------------------------------------------------------------------
// clmul_pkg
// Shared definitions for the Karatsuba carry-less partial-product generator.
//   HALF_W_DEF : default half-operand width
//   FULL_W     : width of one half-by-half carry-less product (2*HALF_W_DEF-1)
//   state_t    : control FSM states
//   half_t     : one half-operand word at the default width
//   prod_t     : one partial product word at the default width
// Optional build macro: CLMUL_ZERO_SKIP_EN (see clmul_kara_pp).
// -----------------------------------------------------------------------------
package clmul_pkg;

  localparam int HALF_W_DEF = 16;
  localparam int FULL_W     = 2 * HALF_W_DEF - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [HALF_W_DEF-1:0] half_t;
  typedef logic [FULL_W-1:0]     prod_t;

endpackage

// File: rtl/clmul_serial_core.sv
// -----------------------------------------------------------------------------
// clmul_serial_core
// One shift-and-XOR carry-less multiply engine. It consumes BPC multiplier
// bits per step, LSB first.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : capture mcand_in (zero-extended) and mult_in, clear acc
//   step       : perform one BPC-bit step
//   mcand_in   : multiplicand, HALF_W bits
//   mult_in    : multiplier, HALF_W bits
//   mult_zero  : multiplier shift register is all zero
//                (present only with CLMUL_ZERO_SKIP_EN)
//   acc        : accumulated product, 2*HALF_W-1 bits
// Optional build macro: CLMUL_ZERO_SKIP_EN adds the mult_zero flag.
// -----------------------------------------------------------------------------
module clmul_serial_core
  import clmul_pkg::*;
#(
  parameter int HALF_W = HALF_W_DEF,
  parameter int BPC    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [HALF_W-1:0]     mcand_in,
  input  logic [HALF_W-1:0]     mult_in,
`ifdef CLMUL_ZERO_SKIP_EN
  output logic                  mult_zero,
`endif
  output logic [2*HALF_W-2:0]   acc
);

  localparam int PROD_W = 2 * HALF_W - 1;

  logic [PROD_W-1:0] mcand_reg;
  logic [PROD_W-1:0] acc_reg;
  logic [HALF_W-1:0] mult_reg;

  // XOR chain across the BPC bits handled in one step; bit k of the
  // multiplier selects the multiplicand shifted left by k.
  logic [PROD_W-1:0] acc_chain [BPC+1];

  assign acc_chain[0] = acc_reg;

  genvar gi;
  generate
    for (gi = 0; gi < BPC; gi++) begin : g_bit
      assign acc_chain[gi+1] = mult_reg[gi] ? (acc_chain[gi] ^ (mcand_reg << gi))
                                            : acc_chain[gi];
    end
  endgenerate

  // The multiplicand never reaches beyond bit 2*HALF_W-2 while a step still
  // uses it, so the product width needs no guard bits. The final post-step
  // shift may push bits out, but that value is never consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_reg <= '0;
      mult_reg  <= '0;
      acc_reg   <= '0;
    end else if (load) begin
      mcand_reg <= PROD_W'(mcand_in);
      mult_reg  <= mult_in;
      acc_reg   <= '0;
    end else if (step) begin
      acc_reg   <= acc_chain[BPC];
      mcand_reg <= mcand_reg << BPC;
      mult_reg  <= mult_reg >> BPC;
    end
  end

  assign acc = acc_reg;

`ifdef CLMUL_ZERO_SKIP_EN
  assign mult_zero = (mult_reg == '0);
`endif

endmodule

// File: rtl/clmul_kara_pp.sv
// -----------------------------------------------------------------------------
// clmul_kara_pp
// Multicycle Karatsuba partial-product generator for a 2*HALF_W x 2*HALF_W
// carry-less multiplier. Produces
//   z0 = clmul(a_lo, b_lo), z1 = clmul(a_lo^a_hi, b_lo^b_hi), z2 = clmul(a_hi, b_hi)
// using three serial engines that run in lock-step.
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : operand pair valid       in_ready  : block can accept
//   a, b       : operands, 2*HALF_W bits
//   out_valid  : z0/z1/z2 valid          out_ready : downstream accepts
//   z0, z1, z2 : partial products, 2*HALF_W-1 bits, held while out_ready=0
// Latency from the accept edge to out_valid is HALF_W/BPC edges.
// Optional build macro: CLMUL_ZERO_SKIP_EN -- leave BUSY early (or skip it
// entirely) once every multiplier shift register is zero; results unchanged.
// BPC must divide HALF_W.
// -----------------------------------------------------------------------------
module clmul_kara_pp
  import clmul_pkg::*;
#(
  parameter int HALF_W = HALF_W_DEF,
  parameter int BPC    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*HALF_W-1:0]   a,
  input  logic [2*HALF_W-1:0]   b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*HALF_W-2:0]   z0,
  output logic [2*HALF_W-2:0]   z1,
  output logic [2*HALF_W-2:0]   z2
);

  localparam int PROD_W = 2 * HALF_W - 1;
  localparam int STEPS  = HALF_W / BPC;
  localparam int CNT_W  = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  counter_reg, counter_next;
  logic              load, step;

  logic [HALF_W-1:0] a_lo, a_hi, b_lo, b_hi;
  logic [HALF_W-1:0] mcand_load [3];
  logic [HALF_W-1:0] mult_load  [3];
  logic [PROD_W-1:0] acc        [3];

  assign a_lo = a[HALF_W-1:0];
  assign a_hi = a[2*HALF_W-1:HALF_W];
  assign b_lo = b[HALF_W-1:0];
  assign b_hi = b[2*HALF_W-1:HALF_W];

  // Engine order: 0 -> z0 (low halves), 1 -> z1 (folded halves), 2 -> z2 (high)
  assign mcand_load[0] = a_lo;
  assign mcand_load[1] = a_lo ^ a_hi;
  assign mcand_load[2] = a_hi;
  assign mult_load[0]  = b_lo;
  assign mult_load[1]  = b_lo ^ b_hi;
  assign mult_load[2]  = b_hi;

`ifdef CLMUL_ZERO_SKIP_EN
  logic [2:0] mult_zero;
  logic       load_zero;

  // b_lo and b_hi both zero implies the folded multiplier is zero too.
  assign load_zero = (b_lo == '0) && (b_hi == '0);
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_eng
      clmul_serial_core #(
        .HALF_W (HALF_W),
        .BPC    (BPC)
      ) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (step),
        .mcand_in  (mcand_load[gi]),
        .mult_in   (mult_load[gi]),
`ifdef CLMUL_ZERO_SKIP_EN
        .mult_zero (mult_zero[gi]),
`endif
        .acc       (acc[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      counter_reg <= '0;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    counter_next = counter_reg;
    load         = 1'b0;
    step         = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;

    unique case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load         = 1'b1;
          counter_next = '0;
          state_next   = BUSY;
`ifdef CLMUL_ZERO_SKIP_EN
          if (load_zero) state_next = DONE;
`endif
        end
      end

      BUSY: begin
`ifdef CLMUL_ZERO_SKIP_EN
        // Nothing left to accumulate: remaining steps would be no-ops.
        if (&mult_zero) begin
          counter_next = '0;
          state_next   = DONE;
        end else
`endif
        begin
          step = 1'b1;
          if (counter_reg == LAST_STEP) begin
            counter_next = '0;
            state_next   = DONE;
          end else begin
            counter_next = counter_reg + 1'b1;
          end
        end
      end

      DONE: begin
        // No acceptance here even if out_ready is high: IDLE comes first.
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end

      default: begin
        state_next   = IDLE;
        counter_next = '0;
      end
    endcase
  end

  assign z0 = acc[0];
  assign z1 = acc[1];
  assign z2 = acc[2];

endmodule
